// File: rtl/ym3438_lfo_ctrl_pkg.sv
// Shared constants, FSM encoding and PMS/AMS field layout for the YM3438 LFO control block.
package ym3438_lfo_ctrl_pkg;

    localparam int SLOTS    = 24;
    localparam int CHANNELS = 6;
    localparam int SLOT_W   = 5;
    localparam int CH_W     = 3;

    localparam logic [7:0] ADDR_TEST    = 8'h21;
    localparam logic [7:0] ADDR_LFO     = 8'h22;
    localparam logic [7:0] ADDR_PMS_AMS = 8'hB4;

    localparam int PMS_LSB = 0;
    localparam int PMS_W   = 3;
    localparam int AMS_LSB = 4;
    localparam int AMS_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic [AMS_W-1:0] ams;
        logic [PMS_W-1:0] pms;
    } pms_ams_t;

    // Each channel owns slots ch, ch+6, ch+12 and ch+18.
    function automatic logic [CH_W-1:0] slot_to_ch(input logic [SLOT_W-1:0] s);
        return CH_W'(s % SLOT_W'(CHANNELS));
    endfunction

endpackage

// File: rtl/ym3438_lfo_ctrl_regfile.sv
// Six-entry PMS/AMS register file: one write port, one registered read port with
// write-through so a same-tick write to the channel being read is seen immediately.
module ym3438_lfo_ctrl_regfile
    import ym3438_lfo_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [CH_W-1:0] i_waddr,
    input  pms_ams_t        i_wdata,
    input  logic            i_re,
    input  logic [CH_W-1:0] i_raddr,
    output pms_ams_t        o_rdata
);

    pms_ams_t r_mem [CHANNELS];
    pms_ams_t r_rdata;

    // NOTE: the storage array is reset explicitly because every PMS/AMS entry must read 0 after IC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments make both ports see the pre-edge contents of r_mem.
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ym3438_lfo_ctrl.sv
// YM3438 LFO control front-end: 24-slot sequencer, write handshake, LFO/test/PMS/AMS registers.
// Define YM_LFO_CTRL_DEFER_EN to defer 0x21/0x22 writes to the slot-23 boundary.
module ym3438_lfo_ctrl
    import ym3438_lfo_ctrl_pkg::*;
(
    input  logic       MCLK,
    input  logic       IC,
    input  logic       c1,
    input  logic       wr_req,
    input  logic [8:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic [4:0] slot,
    output logic       fsm_sel23,
    output logic [3:0] lfo,
    output logic [7:0] reg_21,
    output logic [2:0] pms,
    output logic [1:0] ams,
    output logic       pend
);

    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_next;
    logic              w_last;
    logic [CH_W-1:0]   w_ch_next;

    state_t            r_state;
    state_t            w_state_next;

    logic              w_is_global;
    logic              w_is_chan;
    logic              w_sel_test;
    logic [CH_W-1:0]   w_chan;
    logic              w_chan_we;
    logic              w_glob_take;

    logic [3:0]        r_lfo;
    logic [7:0]        r_reg_21;
    pms_ams_t          w_wfield;
    pms_ams_t          w_rfield;

    assign w_last      = (r_slot == SLOT_W'(SLOTS - 1));
    assign w_slot_next = w_last ? '0 : r_slot + SLOT_W'(1);
    assign w_ch_next   = slot_to_ch(w_slot_next);

    assign w_sel_test  = (wr_addr[7:0] == ADDR_TEST);
    assign w_is_global = w_sel_test || (wr_addr[7:0] == ADDR_LFO);
    assign w_is_chan   = (wr_addr[7:0] >= ADDR_PMS_AMS) && (wr_addr[7:0] <= ADDR_PMS_AMS + 8'd2);
    assign w_chan      = CH_W'(wr_addr[1:0] - ADDR_PMS_AMS[1:0]) + (wr_addr[8] ? CH_W'(3) : CH_W'(0));
    assign w_wfield    = '{ams: wr_data[AMS_LSB +: AMS_W], pms: wr_data[PMS_LSB +: PMS_W]};

`ifdef YM_LFO_CTRL_DEFER_EN
    logic       r_pend;
    logic       r_pend_test;
    logic [7:0] r_pend_data;
`endif

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_slot  <= '0;
            r_state <= ST_IDLE;
        end else if (c1) begin
            r_slot  <= w_slot_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        w_state_next = r_state;
        w_chan_we    = 1'b0;
        w_glob_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (c1 && wr_req) begin
                    w_state_next = ST_ACK;
                    if (w_is_global) begin
`ifdef YM_LFO_CTRL_DEFER_EN
                        if (r_pend) begin
                            w_state_next = ST_STALL;
                        end else begin
                            w_glob_take = 1'b1;
                        end
`else
                        w_glob_take = 1'b1;
`endif
                    end else if (w_is_chan) begin
                        w_chan_we = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (c1) begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef YM_LFO_CTRL_DEFER_EN
            ST_STALL: begin
                // The slot-23 tick drains the buffer, so it can be refilled on that same edge.
                if (c1 && (!r_pend || w_last)) begin
                    w_glob_take  = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef YM_LFO_CTRL_DEFER_EN
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_lfo       <= '0;
            r_reg_21    <= '0;
            r_pend      <= 1'b0;
            r_pend_test <= 1'b0;
            r_pend_data <= '0;
        end else if (c1) begin
            if (w_last && r_pend) begin
                if (r_pend_test) begin
                    r_reg_21 <= r_pend_data;
                end else begin
                    r_lfo <= r_pend_data[3:0];
                end
            end
            if (w_glob_take) begin
                r_pend_test <= w_sel_test;
                r_pend_data <= wr_data;
            end
            r_pend <= w_glob_take || (r_pend && !w_last);
        end
    end

    assign pend = r_pend;
`else
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_lfo    <= '0;
            r_reg_21 <= '0;
        end else if (w_glob_take) begin
            if (w_sel_test) begin
                r_reg_21 <= wr_data;
            end else begin
                r_lfo <= wr_data[3:0];
            end
        end
    end

    assign pend = 1'b0;
`endif

    ym3438_lfo_ctrl_regfile u_regfile (
        .clk     (MCLK),
        .rst_n   (IC),
        .i_we    (w_chan_we),
        .i_waddr (w_chan),
        .i_wdata (w_wfield),
        .i_re    (c1),
        .i_raddr (w_ch_next),
        .o_rdata (w_rfield)
    );

    assign wr_ack    = (r_state == ST_ACK);
    assign slot      = r_slot;
    assign fsm_sel23 = w_last;
    assign lfo       = r_lfo;
    assign reg_21    = r_reg_21;
    assign pms       = w_rfield.pms;
    assign ams       = w_rfield.ams;

endmodule
